vga_rect_filler: RTL and testbench

- Parametrised pixel-stream generator that sits between control logic and vga_adapter's plot interface (x, y, colour, plot).
- On a start pulse it rasters a rectangle, either filled or outline-only, and emits one pixel per transfer.
- Clips pixels to the screen and supports backpressure.
- Replaces manual switch/key plotting of single pixels.

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_raster_walker.sv | 54 +++++
 rtl/vga_rect_filler.sv | 133 +++++++++++++
 tb/tb_vga_rect_filler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel generators: screen sizes, FSM encoding
// and draw-mode selectors.
package vga_pkg;

  localparam int SCREEN_W_160 = 160;
  localparam int SCREEN_H_120 = 120;
  localparam int SCREEN_W_320 = 320;
  localparam int SCREEN_H_240 = 240;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAW   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

endpackage

// File: rtl/vga_raster_walker.sv
// Walks rectangle offsets (i, j): columns inner, rows outer. In outline mode
// interior rows jump straight from the left edge to the right edge.
module vga_raster_walker
  import vga_pkg::*;
#(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 7
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               load,
  input  logic               advance,
  input  logic               mode,
  input  logic [X_WIDTH-1:0] w,
  input  logic [Y_WIDTH-1:0] h,
  output logic [X_WIDTH-1:0] i_next,
  output logic [Y_WIDTH-1:0] j_next,
  output logic               last
);

  logic [X_WIDTH-1:0] i;
  logic [Y_WIDTH-1:0] j;
  logic               row_end;
  logic               edge_row;

  // With w == 1 the row end is also column 0, so single columns never revisit.
  always_comb begin
    row_end  = (i == w - X_WIDTH'(1));
    edge_row = (j == '0) || (j == h - Y_WIDTH'(1));
    last     = row_end && (j == h - Y_WIDTH'(1));
    i_next   = i + X_WIDTH'(1);
    j_next   = j;
    if (row_end) begin
      i_next = '0;
      j_next = j + Y_WIDTH'(1);
    end else if (mode == MODE_OUTLINE && !edge_row && i == '0) begin
      i_next = w - X_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      i <= '0;
      j <= '0;
    end else if (load) begin
      i <= '0;
      j <= '0;
    end else if (advance) begin
      i <= i_next;
      j <= j_next;
    end
  end

endmodule

// File: rtl/vga_rect_filler.sv
// Rasters a filled or outlined rectangle into a plot-style pixel stream with
// screen clipping and plot_ready backpressure.
module vga_rect_filler
  import vga_pkg::*;
#(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = SCREEN_W_160,
  parameter int SCREEN_H     = SCREEN_H_120
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    mode,
  input  logic [X_WIDTH-1:0]      x0,
  input  logic [Y_WIDTH-1:0]      y0,
  input  logic [X_WIDTH-1:0]      w,
  input  logic [Y_WIDTH-1:0]      h,
  input  logic [COLOUR_WIDTH-1:0] colour_in,
  input  logic                    plot_ready,
  output logic [X_WIDTH-1:0]      x,
  output logic [Y_WIDTH-1:0]      y,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    done
);

  localparam logic [X_WIDTH:0] SCR_W = (X_WIDTH+1)'(SCREEN_W);
  localparam logic [Y_WIDTH:0] SCR_H = (Y_WIDTH+1)'(SCREEN_H);

  logic [1:0]         state;
  logic [X_WIDTH-1:0] x0_r;
  logic [Y_WIDTH-1:0] y0_r;
  logic [X_WIDTH-1:0] w_r;
  logic [Y_WIDTH-1:0] h_r;
  logic               mode_r;

  logic [X_WIDTH-1:0] i_next;
  logic [Y_WIDTH-1:0] j_next;
  logic               last;
  logic               load;
  logic               advance;
  logic [X_WIDTH:0]   px_next;
  logic [Y_WIDTH:0]   py_next;
  logic               first_visible;

  // A clipped position (plot low) still consumes its cycle, so it always advances.
  always_comb begin
    load          = (state == ST_IDLE) && start;
    advance       = (state == ST_DRAW) && (plot_ready || !plot);
    px_next       = {1'b0, x0_r} + {1'b0, i_next};
    py_next       = {1'b0, y0_r} + {1'b0, j_next};
    first_visible = ({1'b0, x0} < SCR_W) && ({1'b0, y0} < SCR_H);
  end

  vga_raster_walker #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_walker (
    .clock   (clock),
    .resetn  (resetn),
    .load    (load),
    .advance (advance),
    .mode    (mode_r),
    .w       (w_r),
    .h       (h_r),
    .i_next  (i_next),
    .j_next  (j_next),
    .last    (last)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      x0_r   <= '0;
      y0_r   <= '0;
      w_r    <= '0;
      h_r    <= '0;
      mode_r <= MODE_FILL;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x0_r   <= x0;
            y0_r   <= y0;
            w_r    <= w;
            h_r    <= h;
            mode_r <= mode;
            colour <= colour_in;
            busy   <= 1'b1;
            x      <= x0;
            y      <= y0;
            if (w == '0 || h == '0) begin
              state <= ST_FINISH;
              plot  <= 1'b0;
            end else begin
              state <= ST_DRAW;
              plot  <= first_visible;
            end
          end
        end
        ST_DRAW: begin
          if (advance) begin
            if (last) begin
              state <= ST_FINISH;
              plot  <= 1'b0;
            end else begin
              x    <= px_next[X_WIDTH-1:0];
              y    <= py_next[Y_WIDTH-1:0];
              plot <= (px_next < SCR_W) && (py_next < SCR_H);
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Scoreboard bench for vga_rect_filler: a reference raster model queues the
// expected transfers and a negedge monitor pops them as the DUT plots.
module tb_vga_rect_filler;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic       mode;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour_in;
  logic       plot_ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  logic [17:0] sb[$];
  int compared   = 0;
  int mismatched = 0;
  int xfer_count = 0;

  vga_rect_filler dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .mode       (mode),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .colour_in  (colour_in),
    .plot_ready (plot_ready),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Every transfer must match the head of the expected queue.
  always @(negedge clock) begin
    if (plot === 1'b1 && plot_ready === 1'b1) begin
      logic [17:0] e;
      xfer_count++;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL pixel_unexpected: got (%0d,%0d,c%0d) required none", x, y, colour);
      end else begin
        e = sb.pop_front();
        if ({x, y, colour} !== e) begin
          mismatched++;
          $display("[TB] FAIL pixel: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                   x, y, colour, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  task automatic push_rect(input int m, input int px0, input int py0,
                           input int pw, input int ph, input int col);
    for (int jj = 0; jj < ph; jj++) begin
      for (int ii = 0; ii < pw; ii++) begin
        if (m == 1 && jj != 0 && jj != ph - 1 && ii != 0 && ii != pw - 1) continue;
        if (px0 + ii < 160 && py0 + jj < 120)
          sb.push_back({8'(px0 + ii), 7'(py0 + jj), 3'(col)});
      end
    end
  endtask

  task automatic start_rect(input int m, input int px0, input int py0,
                            input int pw, input int ph, input int col);
    @(posedge clock); #1;
    mode      = m[0];
    x0        = 8'(px0);
    y0        = 7'(py0);
    w         = 8'(pw);
    h         = 7'(ph);
    colour_in = 3'(col);
    start     = 1'b1;
    @(posedge clock); #1;
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int limit, output int first_plot, output int plot_cycles,
                                output int busy_cycles, output int done_cycle);
    first_plot  = 0;
    plot_cycles = 0;
    busy_cycles = 0;
    done_cycle  = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clock);
      if (plot && first_plot == 0) first_plot = k;
      if (plot) plot_cycles++;
      if (busy) busy_cycles++;
      if (done) begin
        done_cycle = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    compared++;
    if ({x, y, colour, plot, busy, done} !== 21'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {x, y, colour, plot, busy, done});
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    compared++;
    if ({plot, busy, done} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL idle_after_reset: got %b required 000", {plot, busy, done});
    end
  endtask

  task automatic test_filled();
    int fp, pc, bc, dc;
    xfer_count = 0;
    push_rect(0, 10, 20, 3, 2, 5);
    start_rect(0, 10, 20, 3, 2, 5);
    run_until_done(100, fp, pc, bc, dc);
    compared += 5;
    if (fp !== 1)  begin mismatched++; $display("[TB] FAIL fill_first_plot: got %0d required 1", fp); end
    if (pc !== 6)  begin mismatched++; $display("[TB] FAIL fill_plot_cycles: got %0d required 6", pc); end
    if (bc !== 7)  begin mismatched++; $display("[TB] FAIL fill_busy_cycles: got %0d required 7", bc); end
    if (dc !== 8)  begin mismatched++; $display("[TB] FAIL fill_done_cycle: got %0d required 8", dc); end
    if (xfer_count !== 6) begin mismatched++; $display("[TB] FAIL fill_xfers: got %0d required 6", xfer_count); end
    @(negedge clock);
    compared++;
    if ({done, busy} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL fill_done_pulse: got %b required 00", {done, busy});
    end
  endtask

  task automatic test_outline();
    int fp, pc, bc, dc;
    xfer_count = 0;
    push_rect(1, 0, 0, 4, 3, 2);
    start_rect(1, 0, 0, 4, 3, 2);
    run_until_done(100, fp, pc, bc, dc);
    compared += 2;
    if (xfer_count !== 10) begin mismatched++; $display("[TB] FAIL outline_xfers: got %0d required 10", xfer_count); end
    if (dc !== 12) begin mismatched++; $display("[TB] FAIL outline_done_cycle: got %0d required 12", dc); end
    xfer_count = 0;
    push_rect(1, 7, 9, 1, 3, 6);
    start_rect(1, 7, 9, 1, 3, 6);
    run_until_done(100, fp, pc, bc, dc);
    compared += 2;
    if (xfer_count !== 3) begin mismatched++; $display("[TB] FAIL outline_w1_xfers: got %0d required 3", xfer_count); end
    if (dc !== 5) begin mismatched++; $display("[TB] FAIL outline_w1_done_cycle: got %0d required 5", dc); end
  endtask

  task automatic test_clipping();
    int fp, pc, bc, dc;
    xfer_count = 0;
    push_rect(0, 158, 119, 4, 2, 4);
    start_rect(0, 158, 119, 4, 2, 4);
    run_until_done(100, fp, pc, bc, dc);
    compared += 3;
    if (pc !== 2)  begin mismatched++; $display("[TB] FAIL clip_plot_cycles: got %0d required 2", pc); end
    if (dc !== 10) begin mismatched++; $display("[TB] FAIL clip_done_cycle: got %0d required 10", dc); end
    if (bc !== 9)  begin mismatched++; $display("[TB] FAIL clip_busy_cycles: got %0d required 9", bc); end
  endtask

  task automatic test_backpressure();
    int fp, pc, bc, dc;
    xfer_count = 0;
    plot_ready = 1'b0;
    push_rect(0, 40, 30, 2, 1, 3);
    start_rect(0, 40, 30, 2, 1, 3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      compared++;
      if ({plot, x, y} !== {1'b1, 8'd40, 7'd30}) begin
        mismatched++;
        $display("[TB] FAIL bp_hold_c%0d: got p%0d (%0d,%0d) required p1 (40,30)", k, plot, x, y);
      end
      if (k == 3) begin
        @(posedge clock); #1;
        plot_ready = 1'b1;
      end
    end
    @(negedge clock);
    compared++;
    if ({plot, x, y} !== {1'b1, 8'd41, 7'd30}) begin
      mismatched++;
      $display("[TB] FAIL bp_second: got p%0d (%0d,%0d) required p1 (41,30)", plot, x, y);
    end
    run_until_done(100, fp, pc, bc, dc);
    compared += 2;
    if (dc !== 2) begin mismatched++; $display("[TB] FAIL bp_done_cycle: got %0d required 2", dc); end
    if (xfer_count !== 2) begin mismatched++; $display("[TB] FAIL bp_xfers: got %0d required 2", xfer_count); end
  endtask

  task automatic test_zero_size();
    int fp, pc, bc, dc;
    xfer_count = 0;
    start_rect(0, 5, 5, 0, 5, 1);
    run_until_done(100, fp, pc, bc, dc);
    compared += 2;
    if (dc !== 2) begin mismatched++; $display("[TB] FAIL zero_done_cycle: got %0d required 2", dc); end
    if (pc !== 0) begin mismatched++; $display("[TB] FAIL zero_plot_cycles: got %0d required 0", pc); end
  endtask

  task automatic test_reset_mid_draw();
    int done_seen = 0, plot_seen = 0;
    xfer_count = 0;
    push_rect(0, 0, 0, 2, 1, 7);
    start_rect(0, 0, 0, 5, 5, 7);
    @(posedge clock); #1;
    resetn = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    compared++;
    if ({plot, busy} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL midreset_state: got %b required 00", {plot, busy});
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done) done_seen++;
      if (plot) plot_seen++;
    end
    compared += 3;
    if (done_seen !== 0) begin mismatched++; $display("[TB] FAIL midreset_done: got %0d required 0", done_seen); end
    if (plot_seen !== 0) begin mismatched++; $display("[TB] FAIL midreset_plot: got %0d required 0", plot_seen); end
    if (xfer_count !== 2) begin mismatched++; $display("[TB] FAIL midreset_xfers: got %0d required 2", xfer_count); end
  endtask

  task automatic test_back_to_back();
    int fp, pc, bc, dc;
    xfer_count = 0;
    push_rect(0, 5, 5, 2, 2, 1);
    start_rect(0, 5, 5, 2, 2, 1);
    @(posedge clock); #1;
    x0 = 8'd50; y0 = 7'd50; w = 8'd7; h = 7'd7; colour_in = 3'd7; mode = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    run_until_done(100, fp, pc, bc, dc);
    compared += 2;
    if (dc !== 4) begin mismatched++; $display("[TB] FAIL busy_start_done_cycle: got %0d required 4", dc); end
    if (xfer_count !== 4) begin mismatched++; $display("[TB] FAIL busy_start_xfers: got %0d required 4", xfer_count); end
    xfer_count = 0;
    push_rect(0, 30, 40, 3, 1, 6);
    start_rect(0, 30, 40, 3, 1, 6);
    run_until_done(100, fp, pc, bc, dc);
    compared += 2;
    if (dc !== 5) begin mismatched++; $display("[TB] FAIL restart_done_cycle: got %0d required 5", dc); end
    if (xfer_count !== 3) begin mismatched++; $display("[TB] FAIL restart_xfers: got %0d required 3", xfer_count); end
  endtask

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    x0         = '0;
    y0         = '0;
    w          = '0;
    h          = '0;
    colour_in  = '0;
    plot_ready = 1'b1;
    test_reset();
    test_filled();
    test_outline();
    test_clipping();
    test_backpressure();
    test_zero_size();
    test_reset_mid_draw();
    test_back_to_back();
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
